// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbitration interface.
// The requesting side (master modport) drives one level request per source plus
// a lock hint. The arbiter (slave modport) returns a one-hot grant, the encoded
// select code for the bus mux, an ownership flag and a busy flag.
interface bus_source_arbiter_if;
    logic [31:0] req;
    logic        lock;
    logic [31:0] gnt;
    logic [4:0]  sel;
    logic        bus_valid;
    logic        busy;

    modport master (
        output req,
        output lock,
        input  gnt,
        input  sel,
        input  bus_valid,
        input  busy
    );

    modport slave (
        input  req,
        input  lock,
        output gnt,
        output sel,
        output bus_valid,
        output busy
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the shared 32-bit datapath bus.
//
// Sources R0-R15 use codes 0-15. The special sources use HI=16, LO=17,
// Zhigh=18, Zlow=19, PC=20, MDR=21, InPort=22 and C=23. Codes 24-31 are spare.
// Exactly one source owns the bus at a time. A single GAP cycle always separates
// two owners. A tenure limit forces the owner off the bus when others are waiting,
// unless the owner holds lock.
//
// Optional build macro BUS_ARB_PARK_EN: when defined, sel keeps the last owner's
// code during GAP and IDLE instead of returning to 0. This keeps the mux parked.
// gnt and bus_valid are unaffected, and reset still clears sel.
module bus_source_arbiter #(
    parameter logic [31:0] REQ_MASK = 32'h00FF_FFFF,
    parameter int          MAX_HOLD = 8,
    parameter int          CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    bus_source_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] TENURE_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TENURE_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             PREEMPT_ON = (MAX_HOLD != 0);

    // Registered state and outputs
    state_t           state_q,      state_d;
    logic [CNT_W-1:0] tenure_q,     tenure_d;
    logic [4:0]       last_owner_q, last_owner_d;
    logic [31:0]      gnt_q,        gnt_d;
    logic [4:0]       sel_q,        sel_d;
    logic             bus_valid_q,  bus_valid_d;
    logic             busy_q,       busy_d;

    // Combinational helpers
    logic [31:0] ereq_s;
    logic [31:0] others_s;
    logic [5:0]  pick_s;
    logic        owner_req_s;
    logic        preempt_s;
    logic [4:0]  sel_idle_s;

    // Walk upward from last+1 with wrap-around. The offset 32 term is the last
    // owner itself, so it is tried last. Iterating downward lets the nearest
    // set bit overwrite any farther one. Bit 5 of the result flags a hit.
    function automatic logic [5:0] rr_pick(input logic [31:0] r, input logic [4:0] last);
        logic [5:0] res;
        logic [4:0] idx;
        res = 6'd0;
        for (int i = 32; i >= 1; i--) begin
            idx = last + 5'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

    // Masked requests, round-robin winner and the OWN-state exit conditions
    always_comb begin
        ereq_s      = bus.req & REQ_MASK;
        others_s    = ereq_s & ~onehot(last_owner_q);
        pick_s      = rr_pick(ereq_s, last_owner_q);
        owner_req_s = bus.req[last_owner_q];
        preempt_s   = PREEMPT_ON && (tenure_q >= HOLD_LIMIT) && !bus.lock && (others_s != 32'd0);
`ifdef BUS_ARB_PARK_EN
        sel_idle_s  = sel_q;
`else
        sel_idle_s  = 5'd0;
`endif
    end

    // Next-state and next-output logic for the IDLE / OWN / GAP controller
    always_comb begin
        state_d      = state_q;
        tenure_d     = tenure_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        bus_valid_d  = bus_valid_q;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_s[5]) begin
                    state_d      = ST_OWN;
                    tenure_d     = TENURE_ONE;
                    last_owner_d = pick_s[4:0];
                    gnt_d        = onehot(pick_s[4:0]);
                    sel_d        = pick_s[4:0];
                    bus_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                    tenure_d     = {CNT_W{1'b0}};
                    gnt_d        = 32'd0;
                    sel_d        = sel_idle_s;
                    bus_valid_d  = 1'b0;
                    busy_d       = 1'b0;
                end
            end

            ST_OWN: begin
                if (!owner_req_s || preempt_s) begin
                    // Voluntary release or forced release both drop the grant
                    // on the same edge as bus_valid.
                    state_d     = ST_GAP;
                    tenure_d    = {CNT_W{1'b0}};
                    gnt_d       = 32'd0;
                    sel_d       = sel_idle_s;
                    bus_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end else begin
                    state_d     = ST_OWN;
                    tenure_d    = (tenure_q == TENURE_MAX) ? TENURE_MAX : tenure_q + TENURE_ONE;
                    gnt_d       = gnt_q;
                    sel_d       = sel_q;
                    bus_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_GAP: begin
                // The turnaround cycle always returns to IDLE. The next winner is
                // chosen there, so ownership never passes directly to another source.
                state_d     = ST_IDLE;
                tenure_d    = {CNT_W{1'b0}};
                gnt_d       = 32'd0;
                sel_d       = sel_idle_s;
                bus_valid_d = 1'b0;
                busy_d      = 1'b0;
            end

            default: begin
                state_d      = ST_IDLE;
                tenure_d     = {CNT_W{1'b0}};
                last_owner_d = 5'd31;
                gnt_d        = 32'd0;
                sel_d        = 5'd0;
                bus_valid_d  = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous clear. A clear during
    // ownership drops the grant at once, without a GAP cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            tenure_q     <= {CNT_W{1'b0}};
            last_owner_q <= 5'd31;
            gnt_q        <= 32'd0;
            sel_q        <= 5'd0;
            bus_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tenure_q     <= tenure_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            bus_valid_q  <= bus_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Directed self-checking bench for bus_source_arbiter.
// dut uses the default parameters. dut2 uses MAX_HOLD=2 for the fairness sequence.
module tb_bus_source_arbiter;

    logic clk;
    logic clr;
    int   chk_cnt;
    int   pass_cnt;

    bus_source_arbiter_if bif ();
    bus_source_arbiter_if bif2 ();

    bus_source_arbiter dut (
        .clk (clk),
        .clr (clr),
        .bus (bif.slave)
    );

    bus_source_arbiter #(.MAX_HOLD(2)) dut2 (
        .clk (clk),
        .clr (clr),
        .bus (bif2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BUS_ARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; bif.req = 32'd0; bif.lock = 1'b0; bif2.req = 32'd0; bif2.lock = 1'b0;
        tick(2);
        chk_cnt++; if (bif.gnt !== 32'd0) $display("FAIL reset_gnt: got %h want %h", bif.gnt, 32'd0); else pass_cnt++;
        chk_cnt++; if (bif.sel !== 5'd0) $display("FAIL reset_sel: got %0d want 0", bif.sel); else pass_cnt++;
        chk_cnt++; if (bif.bus_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bif.bus_valid); else pass_cnt++;
        chk_cnt++; if (bif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bif.busy); else pass_cnt++;
        clr = 1'b0;
    endtask

    task automatic test_single();
        logic [4:0] park_sel;
        park_sel = PARK ? 5'd4 : 5'd0;
        bif.req = 32'h0000_0010;
        tick(1);
        chk_cnt++; if (bif.gnt !== 32'h10) $display("FAIL single_gnt: got %h want %h", bif.gnt, 32'h10); else pass_cnt++;
        chk_cnt++; if (bif.sel !== 5'd4) $display("FAIL single_sel: got %0d want 4", bif.sel); else pass_cnt++;
        chk_cnt++; if (bif.bus_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bif.bus_valid); else pass_cnt++;
        chk_cnt++; if (bif.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bif.busy); else pass_cnt++;
        bif.req = 32'd0;
        tick(1);
        chk_cnt++; if (bif.gnt !== 32'd0) $display("FAIL gap_gnt: got %h want 0", bif.gnt); else pass_cnt++;
        chk_cnt++; if (bif.bus_valid !== 1'b0) $display("FAIL gap_valid: got %b want 0", bif.bus_valid); else pass_cnt++;
        chk_cnt++; if (bif.busy !== 1'b1) $display("FAIL gap_busy: got %b want 1", bif.busy); else pass_cnt++;
        chk_cnt++; if (bif.sel !== park_sel) $display("FAIL gap_sel: got %0d want %0d", bif.sel, park_sel); else pass_cnt++;
        tick(1);
        chk_cnt++; if (bif.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bif.busy); else pass_cnt++;
        chk_cnt++; if (bif.sel !== park_sel) $display("FAIL idle_sel: got %0d want %0d", bif.sel, park_sel); else pass_cnt++;
    endtask

    task automatic test_masking();
        bif.req = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_cnt++; if (bif.gnt !== 32'd0) $display("FAIL mask_gnt%0d: got %h want 0", i, bif.gnt); else pass_cnt++;
            chk_cnt++; if (bif.busy !== 1'b0) $display("FAIL mask_busy%0d: got %b want 0", i, bif.busy); else pass_cnt++;
        end
        bif.req = 32'h8080_0000;
        tick(1);
        chk_cnt++; if (bif.sel !== 5'd23) $display("FAIL mask_sel23: got %0d want 23", bif.sel); else pass_cnt++;
        chk_cnt++; if (bif.gnt !== 32'h0080_0000) $display("FAIL mask_gnt23: got %h want %h", bif.gnt, 32'h0080_0000); else pass_cnt++;
        bif.req = 32'd0;
        tick(2);
    endtask

    task automatic test_lock();
        bif.lock = 1'b1;
        bif.req  = 32'h0010_0000;
        tick(1);
        chk_cnt++; if (bif.sel !== 5'd20) $display("FAIL lock_sel: got %0d want 20", bif.sel); else pass_cnt++;
        bif.req = 32'h0010_0001;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk_cnt++; if (bif.gnt !== 32'h0010_0000) $display("FAIL lock_hold%0d: got %h want %h", i, bif.gnt, 32'h0010_0000); else pass_cnt++;
        end
        bif.lock = 1'b0;
        tick(1);
        chk_cnt++; if (bif.gnt !== 32'd0) $display("FAIL unlock_gap_gnt: got %h want 0", bif.gnt); else pass_cnt++;
        chk_cnt++; if (bif.bus_valid !== 1'b0) $display("FAIL unlock_gap_valid: got %b want 0", bif.bus_valid); else pass_cnt++;
        tick(1);
        chk_cnt++; if (bif.gnt !== 32'd0) $display("FAIL unlock_idle_gnt: got %h want 0", bif.gnt); else pass_cnt++;
        tick(1);
        chk_cnt++; if (bif.gnt !== 32'h1) $display("FAIL unlock_r0_gnt: got %h want 1", bif.gnt); else pass_cnt++;
        chk_cnt++; if (bif.sel !== 5'd0 || bif.bus_valid !== 1'b1) $display("FAIL unlock_r0_sel: got sel %0d valid %b want sel 0 valid 1", bif.sel, bif.bus_valid); else pass_cnt++;
        bif.req = 32'd0;
        tick(2);
    endtask

    task automatic test_no_contender();
        bif.req = 32'h0000_0002;
        tick(1);
        chk_cnt++; if (bif.sel !== 5'd1) $display("FAIL solo_sel: got %0d want 1", bif.sel); else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk_cnt++; if (bif.gnt !== 32'h2) $display("FAIL solo_hold%0d: got %h want 2", i, bif.gnt); else pass_cnt++;
        end
        bif.req = 32'h0000_000A;
        tick(1);
        chk_cnt++; if (bif.gnt !== 32'd0 || bif.busy !== 1'b1) $display("FAIL solo_preempt: got gnt %h busy %b want 0/1", bif.gnt, bif.busy); else pass_cnt++;
        bif.req = 32'd0;
        tick(1);
        chk_cnt++; if (bif.busy !== 1'b0) $display("FAIL solo_idle_busy: got %b want 0", bif.busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bif.req = 32'h0000_0020;
        tick(1);
        chk_cnt++; if (bif.sel !== 5'd5) $display("FAIL rmid_own_sel: got %0d want 5", bif.sel); else pass_cnt++;
        clr = 1'b1;
        bif.req = 32'h0000_0060;
        tick(1);
        chk_cnt++; if (bif.gnt !== 32'd0) $display("FAIL rmid_gnt: got %h want 0", bif.gnt); else pass_cnt++;
        chk_cnt++; if (bif.sel !== 5'd0) $display("FAIL rmid_sel: got %0d want 0", bif.sel); else pass_cnt++;
        chk_cnt++; if (bif.busy !== 1'b0 || bif.bus_valid !== 1'b0) $display("FAIL rmid_busy: got busy %b valid %b want 0/0", bif.busy, bif.bus_valid); else pass_cnt++;
        clr = 1'b0;
        tick(1);
        chk_cnt++; if (bif.sel !== 5'd5 || bif.gnt !== 32'h20) $display("FAIL rmid_regrant: got sel %0d gnt %h want 5/20", bif.sel, bif.gnt); else pass_cnt++;
        bif.req = 32'd0;
        tick(2);
    endtask

    // Order R0, R1, LO, R0. Each tenure is 2 cycles, followed by GAP then IDLE.
    task automatic test_fairness();
        logic [4:0]  order [4];
        logic [31:0] exp_gnt;
        logic [4:0]  exp_sel;
        logic        exp_valid;
        order[0] = 5'd0; order[1] = 5'd1; order[2] = 5'd17; order[3] = 5'd0;
        bif2.req = 32'h0002_0003;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            exp_valid = ((c % 4) < 2);
            exp_sel   = order[c / 4];
            exp_gnt   = exp_valid ? (32'd1 << exp_sel) : 32'd0;
            chk_cnt++; if (bif2.gnt !== exp_gnt || bif2.bus_valid !== exp_valid) $display("FAIL rr_gnt%0d: got %h/%b want %h/%b", c, bif2.gnt, bif2.bus_valid, exp_gnt, exp_valid); else pass_cnt++;
            if (exp_valid) begin
                chk_cnt++; if (bif2.sel !== exp_sel) $display("FAIL rr_sel%0d: got %0d want %0d", c, bif2.sel, exp_sel); else pass_cnt++;
            end
        end
        bif2.req = 32'd0;
        tick(2);
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        clr = 1'b1;
        bif.req = 32'd0; bif.lock = 1'b0; bif2.req = 32'd0; bif2.lock = 1'b0;
        test_reset();
        test_single();
        test_masking();
        test_lock();
        test_no_contender();
        test_reset_mid();
        test_fairness();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
